ex_seq_shift_alu: RTL
=====================

Name: ex_seq_shift_alu

Overview:
- Parametrised, multi-cycle successor to the combinational EX-stage ALU and shifter.
- Accepts one data-processing op per handshake, then runs the operand-2 shifter iteratively, STEP bits per cycle.
- Performs the ARM-style ALU op and registers result and NZCV in an internal flag register.
- Sits between the ID/EX register and the EX/MEM register; ready/valid on both sides.

Parameters:
WIDTH, 32, datapath width; power of two, 16 to 64.
STEP, 1, bit positions shifted or rotated per SHIFT cycle; power of two, at most WIDTH/2.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept (IDLE only)
op  in  4  ALU opcode, same 16-entry encoding as the EX ALU (AND..MVN)
s_bit  in  1  update flags
a  in  WIDTH  Rn operand
b  in  WIDTH  Rm operand
imm  in  12  shifter field
i_cmd  in  1  1=rotated 8-bit immediate, 0=Rm shifted by immediate
flush  in  1  synchronous abort of in-flight op
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
result  out  WIDTH  ALU result
wb_en  out  1  result is to be written back (0 for TST/TEQ/CMP/CMN)
flags  out  4  {N,Z,C,V} flag register

Behaviour:
- Reset (rst_n low, any time, mid-op included): state IDLE; result=0, wb_en=0, out_valid=0, flags=4'b0000. in_ready=1 once rst_n is high.
- States:
  - IDLE: on in_valid&in_ready, latch all inputs. Next state is SHIFT if the shift amount n>0, else EXEC.
  - SHIFT: shift STEP positions per cycle for ceil(n/STEP) cycles. The final step shifts only the remaining n mod STEP positions. Then go to EXEC.
  - EXEC: compute the op, register result/wb_en/flags, go to DONE.
  - DONE: out_valid=1. result and wb_en are held stable until out_ready; on out_ready go to IDLE. in_ready=0 in DONE; there is no pipelined overlap.
- Latency: out_valid rises after edge E0+1+ceil(n/STEP), where E0 is the accept edge.
- Operand 2 when i_cmd=1: zero-extended imm[7:0] rotated right by n=2*imm[11:8], taken mod WIDTH.
- Operand 2 when i_cmd=0: b shifted by n=imm[11:7] mod WIDTH, with imm[6:5] selecting the shift type:
  - 00 LSL
  - 01 LSR
  - 10 ASR, replicating the sign bit
  - 11 ROR
- Shifter carry-out is the last bit shifted out. For n=0 it is the current C flag. For a rotated immediate with n>0 it is bit WIDTH-1.
- Arithmetic:
  - Computed at WIDTH+1 bits.
  - ADC/SBC/RSC use the registered C flag; the input carry port is gone.
  - C = carry out for adds, NOT borrow for subtracts.
  - V = signed overflow of the effective add/subtract.
- Logical ops: C = shifter carry-out; V unchanged.
- Flag update:
  - Flags are updated in EXEC when s_bit=1, or always for TST/TEQ/CMP/CMN.
  - Compare ops: wb_en=0, result=0.
  - N=result[WIDTH-1]; Z=(result==0).
- flush: in SHIFT or EXEC, go to IDLE next edge, no out_valid, flags unchanged. In DONE, drop out_valid and go to IDLE; the flags already written stay. In IDLE it has no effect, and flush takes priority over in_valid on that edge.
- flush and out_ready in the same DONE cycle: same result as flush; no change.

Optional Feature:
EX_BARREL_SHIFT_EN
- Defined: SHIFT state is not built. The full shift is done combinationally in EXEC, so out_valid rises at E0+1 for every n. STEP is ignored. Results and flags are identical.
- Undefined: iterative shifter as described above.

Test Plan:
1. Assert rst_n=0 mid-SHIFT -> out_valid=0, flags=0000, result=0, in_ready=1 after release.
2. ADD, S=1, a=0x4000_0005, b=0x4000_071D, i_cmd=0, imm=0 -> result=0x8000_0722, NZCV=1001, wb_en=1, out_valid at E0+1.
3. SUB S=1, a=5, b=7 -> 0xFFFF_FFFE, NZCV=1000. Then CMP a=7, b=7 -> wb_en=0, result=0, NZCV=0110. Then ADC a=1, b=1 (C=1) -> result=3.
4. MOV S=1, i_cmd=1, imm=0x26A, STEP=1 -> result=0xA000_0006, NZCV=1010 (V keeps prior 0), out_valid at E0+5. Rerun with EX_BARREL_SHIFT_EN: out_valid at E0+1.
5. MOV S=1, i_cmd=0, b=0xEB00_0007, imm=0x2C5 (ASR #5) -> result=0xFF58_0000, N=1, Z=0, C=0.
6. Hold out_ready=0 for 3 cycles in DONE -> result stable, in_ready=0. Separately, assert flush during SHIFT -> no out_valid, flags unchanged, next op accepted.

Source files
------------

// File: rtl/ex_seq_shift_alu_if.sv
// ex_seq_shift_alu_if: handshake and data bundle for the sequential
// shift/ALU EX stage.
//   Upstream side (ID/EX):  in_valid, in_ready, op, s_bit, a, b, imm, i_cmd, flush
//   Downstream side (EX/MEM): out_valid, out_ready, result, wb_en, flags
// Modports:
//   master - the producer/consumer environment around the stage
//   slave  - the stage itself
interface ex_seq_shift_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic             s_bit;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [11:0]      imm;
  logic             i_cmd;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             wb_en;
  logic [3:0]       flags;

  modport master (
    output in_valid, op, s_bit, a, b, imm, i_cmd, flush, out_ready,
    input  in_ready, out_valid, result, wb_en, flags
  );

  modport slave (
    input  in_valid, op, s_bit, a, b, imm, i_cmd, flush, out_ready,
    output in_ready, out_valid, result, wb_en, flags
  );
endinterface

// File: rtl/ex_seq_shift_alu.sv
// ex_seq_shift_alu: multi-cycle EX stage. Accepts one data-processing op per
// handshake, shifts operand 2 iteratively (STEP bit positions per cycle),
// then performs the ARM-style ALU op and registers result, wb_en and NZCV.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - ex_seq_shift_alu_if.slave (in/out handshakes, operands, result, flags)
// Parameters:
//   WIDTH  - datapath width (power of two, 16..64)
//   STEP   - positions shifted per SHIFT cycle (power of two, <= WIDTH/2)
// Build option:
//   EX_BARREL_SHIFT_EN - when defined, the SHIFT state is removed and the
//   whole shift happens combinationally in EXEC (STEP is then unused).
module ex_seq_shift_alu #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  ex_seq_shift_alu_if.slave  bus
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] ONE_SW = {{(SW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Shift val by amt positions of the given type; returns {carry_out, value}.
  // amt==0 passes val through and keeps cin as the carry.
  function automatic logic [WIDTH:0] shift_fn(
    input logic [WIDTH-1:0] val,
    input logic [1:0]       typ,
    input logic [SW-1:0]    amt,
    input logic             cin
  );
    logic [WIDTH-1:0] res;
    logic             co;
    logic [SW-1:0]    idx_lo;  // amt-1: last bit out for right shifts
    logic [SW-1:0]    idx_hi;  // WIDTH-amt: last bit out for left shifts
    idx_lo = amt - ONE_SW;
    idx_hi = (~amt) + ONE_SW;
    if (amt == {SW{1'b0}}) begin
      res = val;
      co  = cin;
    end else begin
      case (typ)
        2'b00: begin
          res = val << amt;
          co  = val[idx_hi];
        end
        2'b01: begin
          res = val >> amt;
          co  = val[idx_lo];
        end
        2'b10: begin
          res = $signed(val) >>> amt;
          co  = val[idx_lo];
        end
        2'b11: begin
          res = (val >> amt) | (val << idx_hi);
          co  = val[idx_lo];
        end
        default: begin
          res = val;
          co  = cin;
        end
      endcase
    end
    return {co, res};
  endfunction

  state_t           state_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             wb_en_r;
  logic [3:0]       flags_r;     // {N,Z,C,V}

  logic [3:0]       op_r;
  logic             s_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] opnd_r;      // operand 2 as it is being shifted
  logic [1:0]       type_r;
  logic [SW-1:0]    rem_r;       // positions still to shift
  logic             sh_c_r;      // shifter carry so far

  logic [SW-1:0]    n_s;
  logic [WIDTH-1:0] opnd_in_s;
  logic [1:0]       type_in_s;

  logic [WIDTH-1:0] op2_s;
  logic             sh_co_s;
  logic [WIDTH-1:0] x_s;
  logic [WIDTH-1:0] y_s;
  logic             ci_s;
  logic             arith_s;
  logic [WIDTH-1:0] log_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] res_s;
  logic             c_s;
  logic             v_s;
  logic             cmp_s;
  logic             upd_s;

  // Decode the shifter field of the incoming op: source, type and amount mod WIDTH.
  always_comb begin
    if (bus.i_cmd) begin
      n_s       = SW'({bus.imm[11:8], 1'b0});
      opnd_in_s = {{(WIDTH-8){1'b0}}, bus.imm[7:0]};
      type_in_s = 2'b11;
    end else begin
      n_s       = SW'(bus.imm[11:7]);
      opnd_in_s = bus.b;
      type_in_s = bus.imm[6:5];
    end
  end

`ifndef EX_BARREL_SHIFT_EN
  localparam logic [SW-1:0] STEP_SW = SW'(STEP);
  logic [SW-1:0] step_amt_s;

  // Amount for this SHIFT cycle: STEP, or the remainder on the final step.
  always_comb begin
    if (rem_r > STEP_SW) begin
      step_amt_s = STEP_SW;
    end else begin
      step_amt_s = rem_r;
    end
  end
`endif

  // EXEC datapath. In the iterative build rem_r is already zero here, so the
  // shifter only passes the accumulated operand and carry through; in the
  // barrel build it performs the full shift.
  always_comb begin
    {sh_co_s, op2_s} = shift_fn(opnd_r, type_r, rem_r, sh_c_r);
    x_s     = a_r;
    y_s     = op2_s;
    ci_s    = 1'b0;
    arith_s = 1'b0;
    log_s   = {WIDTH{1'b0}};
    // Subtracts are x + ~y + carry-in so that C comes out as NOT borrow.
    case (op_r)
      4'h0: log_s = a_r & op2_s;                                             // AND
      4'h1: log_s = a_r ^ op2_s;                                             // EOR
      4'h2: begin y_s = ~op2_s; ci_s = 1'b1; arith_s = 1'b1; end             // SUB
      4'h3: begin x_s = op2_s; y_s = ~a_r; ci_s = 1'b1; arith_s = 1'b1; end  // RSB
      4'h4: arith_s = 1'b1;                                                  // ADD
      4'h5: begin ci_s = flags_r[1]; arith_s = 1'b1; end                     // ADC
      4'h6: begin y_s = ~op2_s; ci_s = flags_r[1]; arith_s = 1'b1; end       // SBC
      4'h7: begin x_s = op2_s; y_s = ~a_r; ci_s = flags_r[1]; arith_s = 1'b1; end // RSC
      4'h8: log_s = a_r & op2_s;                                             // TST
      4'h9: log_s = a_r ^ op2_s;                                             // TEQ
      4'hA: begin y_s = ~op2_s; ci_s = 1'b1; arith_s = 1'b1; end             // CMP
      4'hB: arith_s = 1'b1;                                                  // CMN
      4'hC: log_s = a_r | op2_s;                                             // ORR
      4'hD: log_s = op2_s;                                                   // MOV
      4'hE: log_s = a_r & ~op2_s;                                            // BIC
      4'hF: log_s = ~op2_s;                                                  // MVN
      default: log_s = {WIDTH{1'b0}};
    endcase
    sum_s = {1'b0, x_s} + {1'b0, y_s} + {{WIDTH{1'b0}}, ci_s};
    if (arith_s) begin
      res_s = sum_s[WIDTH-1:0];
      c_s   = sum_s[WIDTH];
      v_s   = (x_s[WIDTH-1] == y_s[WIDTH-1]) && (sum_s[WIDTH-1] != x_s[WIDTH-1]);
    end else begin
      res_s = log_s;
      c_s   = sh_co_s;
      v_s   = flags_r[0];
    end
    cmp_s = (op_r[3:2] == 2'b10);
    upd_s = s_r | cmp_s;
  end

  // Control FSM with registered handshake outputs, result and flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      wb_en_r     <= 1'b0;
      flags_r     <= 4'b0000;
      op_r        <= 4'h0;
      s_r         <= 1'b0;
      a_r         <= {WIDTH{1'b0}};
      opnd_r      <= {WIDTH{1'b0}};
      type_r      <= 2'b00;
      rem_r       <= {SW{1'b0}};
      sh_c_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // flush in IDLE blocks acceptance on that edge
          if (!bus.flush && bus.in_valid && in_ready_r) begin
            op_r       <= bus.op;
            s_r        <= bus.s_bit;
            a_r        <= bus.a;
            opnd_r     <= opnd_in_s;
            type_r     <= type_in_s;
            rem_r      <= n_s;
            sh_c_r     <= flags_r[1];
            in_ready_r <= 1'b0;
`ifdef EX_BARREL_SHIFT_EN
            state_r    <= EXEC;
`else
            state_r    <= (n_s != {SW{1'b0}}) ? SHIFT : EXEC;
`endif
          end
        end
`ifndef EX_BARREL_SHIFT_EN
        SHIFT: begin
          if (bus.flush) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b1;
          end else begin
            {sh_c_r, opnd_r} <= shift_fn(opnd_r, type_r, step_amt_s, sh_c_r);
            rem_r            <= rem_r - step_amt_s;
            if (rem_r == step_amt_s) begin
              state_r <= EXEC;
            end
          end
        end
`endif
        EXEC: begin
          if (bus.flush) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b1;
          end else begin
            result_r    <= cmp_s ? {WIDTH{1'b0}} : res_s;
            wb_en_r     <= ~cmp_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
            if (upd_s) begin
              flags_r <= {res_s[WIDTH-1], (res_s == {WIDTH{1'b0}}), c_s, v_s};
            end
          end
        end
        DONE: begin
          // flush and out_ready both retire the op; flags already written stay
          if (bus.flush || bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.wb_en     = wb_en_r;
  assign bus.flags     = flags_r;

endmodule
